// File: rtl/sevenseg_bank.sv
// sevenseg_bank
// Multi-digit active-low 7-segment driver for the DE1-SoC HEX displays.
// A packed word of 4-bit digit codes is latched on a load strobe and every digit
// is decoded in parallel. Supports optional hex glyphs, per-digit enables,
// leading-zero blanking and a timed blink/flash sequence.
//
// Ports:
//   clk          system clock
//   rst          asynchronous reset, active-high
//   load         capture data_in / digit_en / lz_blank on this edge
//   data_in      4*NUM_DIGITS digit codes, digit 0 (LSD) in bits [3:0]
//   digit_en     per-digit enable, 0 forces the digit blank
//   lz_blank     1 suppresses leading zeros
//   blink_start  start or restart the blink sequence
//   blink_stop   abort blinking and return to steady display
//   segments     registered active-low segments, digit i in [7i+6:7i] (gfedcba)
//   busy         1 while the blink sequence is running
module sevenseg_bank #(
    parameter int NUM_DIGITS  = 6,
    parameter int HEX_MODE    = 0,
    parameter int BLINK_DIV   = 25000000,
    parameter int FLASH_COUNT = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   data_in,
    input  logic [NUM_DIGITS-1:0]     digit_en,
    input  logic                      lz_blank,
    input  logic                      blink_start,
    input  logic                      blink_stop,
    output logic [7*NUM_DIGITS-1:0]   segments,
    output logic                      busy
);

    localparam int PW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int FW = (FLASH_COUNT > 0) ? $clog2(FLASH_COUNT + 1) : 1;

    typedef enum logic [1:0] {
        STEADY    = 2'd0,
        BLINK_OFF = 2'd1,
        BLINK_ON  = 2'd2
    } state_t;

    state_t                    state, state_next;
    logic [PW-1:0]             prescaler, prescaler_next;
    logic [FW-1:0]             flash_cnt, flash_cnt_next;
    logic [4*NUM_DIGITS-1:0]   data_reg;
    logic [NUM_DIGITS-1:0]     en_reg;
    logic                      lz_reg;
    logic [7*NUM_DIGITS-1:0]   seg_next;

    function automatic logic [6:0] decode(input logic [3:0] code);
        logic [6:0] seg;
        seg = 7'h7F;
        case (code)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            default: seg = 7'h7F;
        endcase
        if (HEX_MODE != 0) begin
            case (code)
                4'hA: seg = 7'b0001000;
                4'hB: seg = 7'b0000011;
                4'hC: seg = 7'b1000110;
                4'hD: seg = 7'b0100001;
                4'hE: seg = 7'b0000110;
                4'hF: seg = 7'b0001110;
                default: ;
            endcase
        end
        return seg;
    endfunction

    // Input latch: load is accepted in any blink state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_reg <= '0;
            en_reg   <= '0;
            lz_reg   <= 1'b0;
        end else if (load) begin
            data_reg <= data_in;
            en_reg   <= digit_en;
            lz_reg   <= lz_blank;
        end
    end

    // Blink FSM: stop beats start beats timer expiry.
    always_comb begin
        state_next     = state;
        prescaler_next = prescaler;
        flash_cnt_next = flash_cnt;
        case (state)
            STEADY: begin
                if (blink_start && !blink_stop) begin
                    state_next     = BLINK_OFF;
                    prescaler_next = '0;
                    flash_cnt_next = '0;
                end
            end
            BLINK_OFF, BLINK_ON: begin
                if (blink_stop) begin
                    state_next     = STEADY;
                    prescaler_next = '0;
                end else if (blink_start) begin
                    state_next     = BLINK_OFF;
                    prescaler_next = '0;
                    flash_cnt_next = '0;
                end else if (prescaler == PW'(BLINK_DIV - 1)) begin
                    prescaler_next = '0;
                    if (state == BLINK_OFF) begin
                        state_next = BLINK_ON;
                        if (FLASH_COUNT != 0)
                            flash_cnt_next = flash_cnt + 1'b1;
                    end else if (FLASH_COUNT != 0 && flash_cnt == FW'(FLASH_COUNT)) begin
                        state_next = STEADY;
                    end else begin
                        state_next = BLINK_OFF;
                    end
                end else begin
                    prescaler_next = prescaler + 1'b1;
                end
            end
            default: begin
                state_next     = STEADY;
                prescaler_next = '0;
                flash_cnt_next = '0;
            end
        endcase
    end

    // Decode with enable, leading-zero and blink blanking. Blanking follows the
    // next state so the display changes on the same edge as busy.
    always_comb begin
        logic       leading;
        logic       nz;
        logic       blank;
        logic [3:0] code;
        seg_next = '1;
        leading  = lz_reg;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            code  = data_reg[4*i +: 4];
            nz    = en_reg[i] && (code != 4'h0);
            blank = !en_reg[i] || (state_next == BLINK_OFF) ||
                    (leading && !nz && (i != 0));
            if (nz)
                leading = 1'b0;
            seg_next[7*i +: 7] = blank ? 7'h7F : decode(code);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= STEADY;
            prescaler <= '0;
            flash_cnt <= '0;
            busy      <= 1'b0;
            segments  <= '1;
        end else begin
            state     <= state_next;
            prescaler <= prescaler_next;
            flash_cnt <= flash_cnt_next;
            busy      <= (state_next != STEADY);
            segments  <= seg_next;
        end
    end

endmodule

// File: tb/tb_sevenseg_bank.sv
module tb_sevenseg_bank;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] SA = 7'b0001000;
    localparam logic [6:0] SC = 7'b1000110;
    localparam logic [6:0] SD = 7'b0100001;
    localparam logic [6:0] SE = 7'b0000110;
    localparam logic [6:0] SF = 7'b0001110;
    localparam logic [6:0] BL = 7'h7F;
    localparam logic [27:0] ALL_BLANK = {BL, BL, BL, BL};
    localparam logic [27:0] LIT_1234  = {S1, S2, S3, S4};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load = 1'b0;
    logic [15:0] data_in = 16'h0;
    logic [3:0]  digit_en = 4'h0;
    logic        lz_blank = 1'b0;
    logic        blink_start = 1'b0;
    logic        blink_stop = 1'b0;
    logic [27:0] seg_hex, seg_dec;
    logic        busy_hex, busy_dec;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    sevenseg_bank #(.NUM_DIGITS(4), .HEX_MODE(1), .BLINK_DIV(4), .FLASH_COUNT(2)) dut_hex (
        .clk(clk), .rst(rst), .load(load), .data_in(data_in), .digit_en(digit_en),
        .lz_blank(lz_blank), .blink_start(blink_start), .blink_stop(blink_stop),
        .segments(seg_hex), .busy(busy_hex)
    );

    sevenseg_bank #(.NUM_DIGITS(4), .HEX_MODE(0), .BLINK_DIV(4), .FLASH_COUNT(2)) dut_dec (
        .clk(clk), .rst(rst), .load(load), .data_in(data_in), .digit_en(digit_en),
        .lz_blank(lz_blank), .blink_start(blink_start), .blink_stop(blink_stop),
        .segments(seg_dec), .busy(busy_dec)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Capture a word and wait for the second edge so the segments are valid.
    task automatic load_word(input logic [15:0] d, input logic [3:0] en, input logic lz);
        data_in  = d;
        digit_en = en;
        lz_blank = lz;
        load     = 1'b1;
        tick();
        load     = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #1;
        total_cnt++;
        if (seg_hex !== ALL_BLANK) $display("FAIL reset_seg: got %h want %h", seg_hex, ALL_BLANK);
        else pass_cnt++;
        total_cnt++;
        if (busy_hex !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_hex);
        else pass_cnt++;
        tick();
        tick();
        rst = 1'b0;
        tick();
        total_cnt++;
        if (seg_hex !== ALL_BLANK) $display("FAIL reset_release_seg: got %h want %h", seg_hex, ALL_BLANK);
        else pass_cnt++;
    endtask

    task automatic test_decode;
        data_in  = 16'h1234;
        digit_en = 4'hF;
        lz_blank = 1'b0;
        load     = 1'b1;
        tick();
        load     = 1'b0;
        total_cnt++;
        if (seg_hex !== ALL_BLANK) $display("FAIL load_latency: got %h want %h", seg_hex, ALL_BLANK);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (seg_hex !== LIT_1234) $display("FAIL decode_1234: got %h want %h", seg_hex, LIT_1234);
        else pass_cnt++;
        total_cnt++;
        if (busy_hex !== 1'b0) $display("FAIL decode_busy: got %b want 0", busy_hex);
        else pass_cnt++;
    endtask

    task automatic test_lz_blank;
        load_word(16'h00A0, 4'hF, 1'b1);
        total_cnt++;
        if (seg_hex !== {BL, BL, SA, S0}) $display("FAIL lz_00A0: got %h want %h", seg_hex, {BL, BL, SA, S0});
        else pass_cnt++;
        load_word(16'h0000, 4'hF, 1'b1);
        total_cnt++;
        if (seg_hex !== {BL, BL, BL, S0}) $display("FAIL lz_0000: got %h want %h", seg_hex, {BL, BL, BL, S0});
        else pass_cnt++;
        // A disabled nonzero digit counts as zero during the scan.
        load_word(16'h5003, 4'b0111, 1'b1);
        total_cnt++;
        if (seg_hex !== {BL, BL, BL, S3}) $display("FAIL lz_disabled_top: got %h want %h", seg_hex, {BL, BL, BL, S3});
        else pass_cnt++;
        load_word(16'h0000, 4'hF, 1'b0);
        total_cnt++;
        if (seg_hex !== {S0, S0, S0, S0}) $display("FAIL lz_off_zeros: got %h want %h", seg_hex, {S0, S0, S0, S0});
        else pass_cnt++;
    endtask

    task automatic test_hex_mode_off;
        load_word(16'hFEDC, 4'hF, 1'b0);
        total_cnt++;
        if (seg_dec !== ALL_BLANK) $display("FAIL dec_FEDC: got %h want %h", seg_dec, ALL_BLANK);
        else pass_cnt++;
        total_cnt++;
        if (seg_hex !== {SF, SE, SD, SC}) $display("FAIL hex_FEDC: got %h want %h", seg_hex, {SF, SE, SD, SC});
        else pass_cnt++;
        load_word(16'h8888, 4'b0101, 1'b0);
        total_cnt++;
        if (seg_dec !== {BL, S8, BL, S8}) $display("FAIL dec_en_0101: got %h want %h", seg_dec, {BL, S8, BL, S8});
        else pass_cnt++;
    endtask

    task automatic test_blink_sequence;
        logic [27:0] exp;
        load_word(16'h1234, 4'hF, 1'b0);
        blink_start = 1'b1;
        tick();
        blink_start = 1'b0;
        for (int c = 0; c < 16; c++) begin
            exp = (((c / 4) % 2) == 0) ? ALL_BLANK : LIT_1234;
            total_cnt++;
            if (seg_hex !== exp) $display("FAIL blink_seg c=%0d: got %h want %h", c, seg_hex, exp);
            else pass_cnt++;
            total_cnt++;
            if (busy_hex !== 1'b1) $display("FAIL blink_busy c=%0d: got %b want 1", c, busy_hex);
            else pass_cnt++;
            tick();
        end
        total_cnt++;
        if (busy_hex !== 1'b0) $display("FAIL blink_done_busy: got %b want 0", busy_hex);
        else pass_cnt++;
        total_cnt++;
        if (seg_hex !== LIT_1234) $display("FAIL blink_done_seg: got %h want %h", seg_hex, LIT_1234);
        else pass_cnt++;
    endtask

    task automatic test_blink_priority;
        // Stop alone and stop+start together in STEADY leave it steady.
        blink_stop = 1'b1;
        tick();
        total_cnt++;
        if (busy_hex !== 1'b0) $display("FAIL steady_stop_busy: got %b want 0", busy_hex);
        else pass_cnt++;
        blink_start = 1'b1;
        tick();
        blink_start = 1'b0;
        blink_stop  = 1'b0;
        total_cnt++;
        if (busy_hex !== 1'b0 || seg_hex !== LIT_1234)
            $display("FAIL steady_both: got busy=%b seg=%h want busy=0 seg=%h", busy_hex, seg_hex, LIT_1234);
        else pass_cnt++;

        // Stop and start together mid-blink: stop wins.
        blink_start = 1'b1;
        tick();
        blink_start = 1'b0;
        tick();
        blink_start = 1'b1;
        blink_stop  = 1'b1;
        tick();
        blink_start = 1'b0;
        blink_stop  = 1'b0;
        total_cnt++;
        if (busy_hex !== 1'b0 || seg_hex !== LIT_1234)
            $display("FAIL stop_priority: got busy=%b seg=%h want busy=0 seg=%h", busy_hex, seg_hex, LIT_1234);
        else pass_cnt++;

        // Restart during BLINK_ON gives a full fresh BLINK_OFF period.
        blink_start = 1'b1;
        tick();
        blink_start = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        total_cnt++;
        if (seg_hex !== LIT_1234) $display("FAIL restart_pre_on: got %h want %h", seg_hex, LIT_1234);
        else pass_cnt++;
        blink_start = 1'b1;
        tick();
        blink_start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            total_cnt++;
            if (seg_hex !== ALL_BLANK || busy_hex !== 1'b1)
                $display("FAIL restart_off c=%0d: got busy=%b seg=%h want busy=1 seg=%h", c, busy_hex, seg_hex, ALL_BLANK);
            else pass_cnt++;
            tick();
        end
        total_cnt++;
        if (seg_hex !== LIT_1234 || busy_hex !== 1'b1)
            $display("FAIL restart_on: got busy=%b seg=%h want busy=1 seg=%h", busy_hex, seg_hex, LIT_1234);
        else pass_cnt++;
        blink_stop = 1'b1;
        tick();
        blink_stop = 1'b0;
        total_cnt++;
        if (busy_hex !== 1'b0) $display("FAIL stop_busy: got %b want 0", busy_hex);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_blink;
        blink_start = 1'b1;
        tick();
        blink_start = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        total_cnt++;
        if (seg_hex !== LIT_1234 || busy_hex !== 1'b1)
            $display("FAIL pre_rst_on: got busy=%b seg=%h want busy=1 seg=%h", busy_hex, seg_hex, LIT_1234);
        else pass_cnt++;
        #2;
        rst = 1'b1;
        #1;
        total_cnt++;
        if (seg_hex !== ALL_BLANK || busy_hex !== 1'b0)
            $display("FAIL async_rst: got busy=%b seg=%h want busy=0 seg=%h", busy_hex, seg_hex, ALL_BLANK);
        else pass_cnt++;
        #1;
        rst = 1'b0;
        for (int c = 0; c < 3; c++) tick();
        total_cnt++;
        if (seg_hex !== ALL_BLANK || busy_hex !== 1'b0)
            $display("FAIL post_rst_blank: got busy=%b seg=%h want busy=0 seg=%h", busy_hex, seg_hex, ALL_BLANK);
        else pass_cnt++;
        load_word(16'h1234, 4'hF, 1'b0);
        total_cnt++;
        if (seg_hex !== LIT_1234) $display("FAIL post_rst_load: got %h want %h", seg_hex, LIT_1234);
        else pass_cnt++;
    endtask

    initial begin
        #1;
        test_reset();
        test_decode();
        test_lz_blank();
        test_hex_mode_off();
        test_blink_sequence();
        test_blink_priority();
        test_reset_mid_blink();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule
